// File: rtl/ber_window_counter.sv
// Multi-channel windowed bit-error / frame-error counter with a valid/ready result port.
// Optional per-channel worst-frame tracking is built only when BER_MAX_TRACK_EN is defined.
module ber_window_counter #(
    parameter int FL    = 104,
    parameter int NCH   = 2,
    parameter int ACC_W = 24,
    parameter int FR_W  = 16,
    parameter int CW    = $clog2(FL + 1)
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  nClear,
    input  logic                  Start,
    input  logic                  cont_mode,
    input  logic [FR_W-1:0]       window_len,
    input  logic                  frame_valid,
    input  logic [NCH*FL-1:0]     b_error,
    output logic                  busy,
    output logic [NCH*CW-1:0]     last_errs,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [NCH*ACC_W-1:0]  bit_err_tot,
    output logic [NCH*FR_W-1:0]   frame_err_tot,
    output logic [FR_W-1:0]       frames_done,
    output logic                  frame_dropped,
    output logic [NCH*CW-1:0]     max_errs
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [FR_W-1:0] len_reg;
    logic [FR_W-1:0] frames_reg;
    logic            dropped_reg;
    logic            s1_valid_reg;

    logic            window_full;
    logic            handshake;
    logic            auto_restart;
    logic            win_clear;
    logic            accept;
    logic            drop_evt;
    logic [FR_W-1:0] eff_len;

    assign window_full  = (frames_reg >= len_reg);
    assign handshake    = (state_reg == S_DONE) && result_ready;
    assign auto_restart = handshake && cont_mode && !Start;
    // Start restarts a window from any state; a frame arriving with it is discarded.
    assign win_clear    = Start || auto_restart;
    assign accept       = (state_reg == S_RUN) && frame_valid && !Start && !window_full;
    assign drop_evt     = frame_valid && !Start &&
                          ((state_reg == S_FLUSH) || (state_reg == S_DONE) ||
                           ((state_reg == S_RUN) && window_full));
    assign eff_len      = (window_len == '0) ? FR_W'(1) : window_len;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (Start) state_next = S_RUN;
            end
            S_RUN: begin
                if (Start)            state_next = S_RUN;
                else if (window_full) state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (Start) state_next = S_RUN;
                else       state_next = S_DONE;
            end
            S_DONE: begin
                if (Start)          state_next = S_RUN;
                else if (handshake) state_next = cont_mode ? S_RUN : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_reg    <= S_IDLE;
            len_reg      <= FR_W'(1);
            frames_reg   <= '0;
            dropped_reg  <= 1'b0;
            s1_valid_reg <= 1'b0;
        end else if (!nClear) begin
            state_reg    <= S_IDLE;
            len_reg      <= FR_W'(1);
            frames_reg   <= '0;
            dropped_reg  <= 1'b0;
            s1_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s1_valid_reg <= accept;
            if (Start) len_reg <= eff_len;
            if (win_clear)   frames_reg <= '0;
            else if (accept) frames_reg <= frames_reg + FR_W'(1);
            // Only an explicit Start clears the sticky flag; continuous restarts keep it.
            if (Start)         dropped_reg <= 1'b0;
            else if (drop_evt) dropped_reg <= 1'b1;
        end
    end

    assign busy          = (state_reg == S_RUN) || (state_reg == S_FLUSH);
    assign result_valid  = (state_reg == S_DONE);
    assign frames_done   = frames_reg;
    assign frame_dropped = dropped_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            logic [CW-1:0]    pop;
            logic [CW-1:0]    pop_reg;
            logic [ACC_W-1:0] bit_reg;
            logic [FR_W-1:0]  ferr_reg;
            logic [ACC_W:0]   bit_sum;

            always_comb begin
                pop = '0;
                for (int b = 0; b < FL; b++) begin
                    pop = pop + CW'(b_error[gi*FL + b]);
                end
            end

            // One spare bit catches the carry so the sum clamps instead of wrapping.
            assign bit_sum = {1'b0, bit_reg} + (ACC_W+1)'(pop_reg);

            always_ff @(posedge Clock or negedge nReset) begin
                if (!nReset) begin
                    pop_reg  <= CW'(FL);
                    bit_reg  <= '0;
                    ferr_reg <= '0;
                end else if (!nClear) begin
                    pop_reg  <= CW'(FL);
                    bit_reg  <= '0;
                    ferr_reg <= '0;
                end else begin
                    if (accept) pop_reg <= pop;
                    if (win_clear) begin
                        bit_reg  <= '0;
                        ferr_reg <= '0;
                    end else if (s1_valid_reg) begin
                        bit_reg <= bit_sum[ACC_W] ? '1 : bit_sum[ACC_W-1:0];
                        if ((pop_reg != '0) && (ferr_reg != '1))
                            ferr_reg <= ferr_reg + FR_W'(1);
                    end
                end
            end

            assign last_errs[gi*CW +: CW]         = pop_reg;
            assign bit_err_tot[gi*ACC_W +: ACC_W] = bit_reg;
            assign frame_err_tot[gi*FR_W +: FR_W] = ferr_reg;

`ifdef BER_MAX_TRACK_EN
            logic [CW-1:0] max_reg;

            always_ff @(posedge Clock or negedge nReset) begin
                if (!nReset) begin
                    max_reg <= '0;
                end else if (!nClear) begin
                    max_reg <= '0;
                end else if (win_clear) begin
                    max_reg <= '0;
                end else if (s1_valid_reg && (pop_reg > max_reg)) begin
                    max_reg <= pop_reg;
                end
            end

            assign max_errs[gi*CW +: CW] = max_reg;
`else
            assign max_errs[gi*CW +: CW] = '0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_ber_window_counter.sv
// Bench for ber_window_counter: directed windows plus randomized windows scored
// against a popcount/saturation model of each window.
module tb_ber_window_counter;

    localparam int FL    = 104;
    localparam int NCH   = 2;
    localparam int ACC_W = 8;
    localparam int FR_W  = 16;
    localparam int CW    = 7;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic                 clk;
    logic                 nReset;
    logic                 nClear;
    logic                 Start;
    logic                 cont_mode;
    logic [FR_W-1:0]      window_len;
    logic                 frame_valid;
    logic [NCH*FL-1:0]    b_error;
    logic                 busy;
    logic [NCH*CW-1:0]    last_errs;
    logic                 result_valid;
    logic                 result_ready;
    logic [NCH*ACC_W-1:0] bit_err_tot;
    logic [NCH*FR_W-1:0]  frame_err_tot;
    logic [FR_W-1:0]      frames_done;
    logic                 frame_dropped;
    logic [NCH*CW-1:0]    max_errs;

    int vectors;
    int miscompares;
    int m_bit[NCH];
    int m_ferr[NCH];
    int m_max[NCH];
    int m_frames;

    ber_window_counter #(.FL(FL), .NCH(NCH), .ACC_W(ACC_W), .FR_W(FR_W)) dut (
        .Clock(clk), .nReset(nReset), .nClear(nClear), .Start(Start),
        .cont_mode(cont_mode), .window_len(window_len), .frame_valid(frame_valid),
        .b_error(b_error), .busy(busy), .last_errs(last_errs),
        .result_valid(result_valid), .result_ready(result_ready),
        .bit_err_tot(bit_err_tot), .frame_err_tot(frame_err_tot),
        .frames_done(frames_done), .frame_dropped(frame_dropped), .max_errs(max_errs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [NCH*FL-1:0] mk(input int p0, input int p1);
        logic [NCH*FL-1:0] v;
        for (int b = 0; b < FL; b++) begin
            v[b]      = (b < p0);
            v[FL + b] = (b < p1);
        end
        return v;
    endfunction

    function automatic logic [NCH*FL-1:0] rand_vec();
        logic [NCH*FL-1:0] v;
        int dens;
        for (int c = 0; c < NCH; c++) begin
            case ($urandom_range(0, 3))
                0:       dens = 0;
                1:       dens = 5;
                2:       dens = 50;
                default: dens = 100;
            endcase
            for (int b = 0; b < FL; b++) v[c*FL + b] = ($urandom_range(0, 99) < dens);
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_bit[c] = 0; m_ferr[c] = 0; m_max[c] = 0;
        end
        m_frames = 0;
    endtask

    // Presents one frame for exactly one edge and checks last_errs just after it.
    task automatic send_frame(input logic [NCH*FL-1:0] vec);
        int p;
        frame_valid = 1'b1;
        b_error     = vec;
        tick();
        frame_valid = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            p = $countones(vec[c*FL +: FL]);
            m_bit[c] = (m_bit[c] + p > ACC_MAX) ? ACC_MAX : m_bit[c] + p;
            if (p != 0) m_ferr[c]++;
            if (p > m_max[c]) m_max[c] = p;
            check($sformatf("last_errs ch%0d", c), 64'(last_errs[c*CW +: CW]), 64'(p));
        end
        m_frames++;
    endtask

    task automatic check_totals(input string tag);
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("%s bit_err ch%0d", tag, c), 64'(bit_err_tot[c*ACC_W +: ACC_W]), 64'(m_bit[c]));
            check($sformatf("%s frame_err ch%0d", tag, c), 64'(frame_err_tot[c*FR_W +: FR_W]), 64'(m_ferr[c]));
`ifdef BER_MAX_TRACK_EN
            check($sformatf("%s max ch%0d", tag, c), 64'(max_errs[c*CW +: CW]), 64'(m_max[c]));
`else
            check($sformatf("%s max ch%0d", tag, c), 64'(max_errs[c*CW +: CW]), 64'd0);
`endif
        end
        check({tag, " frames_done"}, 64'(frames_done), 64'(m_frames));
    endtask

    task automatic start_window(input int len);
        Start      = 1'b1;
        window_len = FR_W'(len);
        tick();
        Start = 1'b0;
        model_clear();
        check("start busy", 64'(busy), 64'd1);
        check("start frames_done", 64'(frames_done), 64'd0);
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!result_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, " result_valid"}, 64'(result_valid), 64'd1);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        int len;
        int nfr;
        vectors = 0; miscompares = 0;
        nReset = 1'b0; nClear = 1'b1; Start = 1'b0; cont_mode = 1'b0;
        window_len = '0; frame_valid = 1'b0; b_error = '0; result_ready = 1'b0;
        model_clear();
        repeat (3) tick();
        nReset = 1'b1;
        tick();

        // Reset / idle state
        for (int c = 0; c < NCH; c++)
            check($sformatf("reset last_errs ch%0d", c), 64'(last_errs[c*CW +: CW]), 64'd104);
        check_totals("reset");
        check("reset result_valid", 64'(result_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset frame_dropped", 64'(frame_dropped), 64'd0);

        // One-shot window of 3 with exact result_valid timing
        start_window(3);
        send_frame(mk(5, 0));
        send_frame(mk(0, 0));
        send_frame(mk(7, 1));
        check("oneshot rv t+1", 64'(result_valid), 64'd0);
        tick();
        check("oneshot rv edge t+1", 64'(result_valid), 64'd0);
        check("oneshot busy flush", 64'(busy), 64'd1);
        tick();
        check("oneshot rv edge t+2", 64'(result_valid), 64'd1);
        check("oneshot busy done", 64'(busy), 64'd0);
        check("oneshot ch0 const", 64'(bit_err_tot[0 +: ACC_W]), 64'd12);
        check("oneshot ferr ch0 const", 64'(frame_err_tot[0 +: FR_W]), 64'd2);
        check_totals("oneshot");

        // Backpressure with frames arriving while DONE
        for (int i = 0; i < 10; i++) begin
            frame_valid = 1'b1;
            b_error = rand_vec();
            tick();
            check("bp result_valid", 64'(result_valid), 64'd1);
            check("bp frozen ch0", 64'(bit_err_tot[0 +: ACC_W]), 64'd12);
        end
        frame_valid = 1'b0;
        check("bp frame_dropped", 64'(frame_dropped), 64'd1);
        check_totals("bp");
        handshake();
        check("bp after hs rv", 64'(result_valid), 64'd0);
        check("bp after hs busy", 64'(busy), 64'd0);
        check_totals("idle hold");
        check("idle dropped sticky", 64'(frame_dropped), 64'd1);

        // Start together with a frame in RUN: restart wins, frame discarded
        start_window(4);
        check("start clears dropped", 64'(frame_dropped), 64'd0);
        send_frame(mk(10, 10));
        Start = 1'b1; window_len = 16'd2; frame_valid = 1'b1; b_error = mk(50, 50);
        tick();
        Start = 1'b0; frame_valid = 1'b0;
        model_clear();
        check("restart frames_done", 64'(frames_done), 64'd0);
        check("restart bit ch0", 64'(bit_err_tot[0 +: ACC_W]), 64'd0);
        check("restart last_errs kept", 64'(last_errs[0 +: CW]), 64'd10);
        tick();
        check("restart no late add", 64'(bit_err_tot[0 +: ACC_W]), 64'd0);
        send_frame(rand_vec());
        send_frame(rand_vec());
        wait_result("restart");
        check_totals("restart");
        handshake();

        // Continuous mode, back-to-back full-error frames
        cont_mode = 1'b1;
        start_window(2);
        for (int w = 0; w < 2; w++) begin
            send_frame(mk(104, 104));
            send_frame(mk(104, 104));
            wait_result("cont");
            check("cont ch0 const", 64'(bit_err_tot[0 +: ACC_W]), 64'd208);
            check_totals("cont");
            if (w == 0) begin
                handshake();
                model_clear();
                check("cont rerun busy", 64'(busy), 64'd1);
                check("cont rerun frames", 64'(frames_done), 64'd0);
                check("cont rerun bit ch1", 64'(bit_err_tot[ACC_W +: ACC_W]), 64'd0);
            end
        end
        cont_mode = 1'b0;
        handshake();
        check("cont exit busy", 64'(busy), 64'd0);

        // Saturation: 4 x 104 = 416 clamps at 255
        start_window(4);
        repeat (4) send_frame(mk(104, 104));
        wait_result("sat");
        check("sat ch0 const", 64'(bit_err_tot[0 +: ACC_W]), 64'd255);
        check_totals("sat");
        handshake();

        // Randomized windows (len 0 behaves as 1)
        for (int i = 0; i < 16; i++) begin
            len = (i == 0) ? 0 : int'($urandom_range(1, 6));
            nfr = (len == 0) ? 1 : len;
            start_window(len);
            for (int f = 0; f < nfr; f++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_frame(rand_vec());
            end
            wait_result("rand");
            check_totals("rand");
            repeat ($urandom_range(0, 3)) tick();
            check("rand rv held", 64'(result_valid), 64'd1);
            handshake();
            check("rand idle", 64'(busy), 64'd0);
        end

        // nClear mid-RUN, then a window for max tracking
        start_window(5);
        send_frame(mk(20, 30));
        send_frame(mk(4, 4));
        nClear = 1'b0;
        tick();
        nClear = 1'b1;
        model_clear();
        check("clr busy", 64'(busy), 64'd0);
        check("clr rv", 64'(result_valid), 64'd0);
        for (int c = 0; c < NCH; c++)
            check($sformatf("clr last_errs ch%0d", c), 64'(last_errs[c*CW +: CW]), 64'd104);
        check_totals("clr");
        tick();
        check_totals("clr settle");
        start_window(3);
        send_frame(mk(3, 1));
        send_frame(mk(9, 1));
        send_frame(mk(2, 1));
        wait_result("max");
        check_totals("max");
`ifdef BER_MAX_TRACK_EN
        check("max ch0 const", 64'(max_errs[0 +: CW]), 64'd9);
`endif
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
